exception_handler: RTL and testbench

EXCEPTION_HANDLER -- requirements
Module: exception_handler

---
 rtl/exc_pkg.sv | 33 +++
 rtl/exc_wait_counter.sv | 25 ++
 rtl/exception_handler.sv | 116 +++++++++++
 tb/tb_exception_handler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer: FSM states, cause codes and vector addresses.
// Pure declarations; no timing or flow-control behaviour.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_READ = 3'd2,
    ST_LOAD = 3'd3,
    ST_RET  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIV0     = 2'b11
  } cause_t;

  localparam logic [31:0] VEC_OPCODE   = 32'd253;
  localparam logic [31:0] VEC_OVERFLOW = 32'd254;
  localparam logic [31:0] VEC_DIV0     = 32'd255;

  function automatic logic [31:0] cause_vector(input cause_t cause);
    case (cause)
      CAUSE_OPCODE:   return VEC_OPCODE;
      CAUSE_OVERFLOW: return VEC_OVERFLOW;
      CAUSE_DIV0:     return VEC_DIV0;
      default:        return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// 4-bit loadable down-counter with zero flag; load wins over decrement, saturates at zero.
// Registered count, zero flag is combinational from count; no backpressure.
module exc_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/exception_handler.sv
// Exception sequencer: save EPC, fetch vector over MEM_WAIT cycles, load PC; or return from exception.
// Request at edge k -> epc_load k+1, pc_load k+2+MEM_WAIT; requests while busy are dropped, not queued.
module exception_handler #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic        rte_req,
  input  logic [31:0] pc_current,
  input  logic [31:0] epc_in,
  input  logic [31:0] mem_rdata,
  output logic        epc_load,
  output logic [31:0] epc_data,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        busy,
  output logic [1:0]  exc_cause
);
  import exc_pkg::*;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t      state, state_nxt;
  cause_t      cause_q, req_cause;
  logic [31:0] epc_q;
  logic [31:0] vec_addr;
  logic        any_exc;
  logic        wait_zero;
  logic [3:0]  unused_wait_count;
  logic        unused_rdata;

  assign any_exc      = exc_opcode | exc_overflow | exc_div0;
  assign unused_rdata = &{1'b0, mem_rdata[31:8]};

  always_comb begin
    req_cause = CAUSE_NONE;
    if (exc_opcode)        req_cause = CAUSE_OPCODE;
    else if (exc_overflow) req_cause = CAUSE_OVERFLOW;
    else if (exc_div0)     req_cause = CAUSE_DIV0;
  end

  // PC arrives already advanced by 4; the faulting instruction sits one word back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      epc_q   <= 32'd0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && any_exc) begin
        cause_q <= req_cause;
        epc_q   <= pc_current - 32'd4;
      end
    end
  end

  // Loaded during SAVE so READ sees MEM_WAIT-1 down to 0.
  exc_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_SAVE),
    .load_val (WAIT_LOAD),
    .dec      (state == ST_READ),
    .count    (unused_wait_count),
    .zero     (wait_zero)
  );

  assign vec_addr  = cause_vector(cause_q);
  assign epc_data  = epc_q;
  assign exc_cause = cause_q;

  always_comb begin
    state_nxt = state;
    epc_load  = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = 32'd0;
    pc_load   = 1'b0;
    pc_next   = 32'd0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (any_exc)      state_nxt = ST_SAVE;
        else if (rte_req) state_nxt = ST_RET;
      end
      ST_SAVE: begin
        epc_load  = 1'b1;
        mem_addr  = vec_addr;
        state_nxt = ST_READ;
      end
      ST_READ: begin
        mem_rd   = 1'b1;
        mem_addr = vec_addr;
        if (wait_zero) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        pc_load   = 1'b1;
        mem_addr  = vec_addr;
        pc_next   = {24'h0, mem_rdata[7:0]};
        state_nxt = ST_IDLE;
      end
      ST_RET: begin
        pc_load   = 1'b1;
        pc_next   = epc_in;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exception_handler.sv
// Bench for exception_handler: directed sequences plus randomized requests against a transaction-level model.
module tb_exception_handler;

  localparam int MW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div0, rte_req;
  logic [31:0] pc_current, epc_in, mem_rdata;
  logic        epc_load, mem_rd, pc_load, busy;
  logic [31:0] epc_data, mem_addr, pc_next;
  logic [1:0]  exc_cause;

  int n_checks = 0;
  int n_fail   = 0;

  // flags {epc_load, mem_rd, pc_load, busy}, epc_data, mem_addr, pc_next, exc_cause
  wire  [101:0] obs = {epc_load, mem_rd, pc_load, busy, epc_data, mem_addr, pc_next, exc_cause};
  logic [101:0] exp_v;

  always #5 clk = ~clk;

  exception_handler #(.MEM_WAIT(MW)) dut (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .rte_req      (rte_req),
    .pc_current   (pc_current),
    .epc_in       (epc_in),
    .mem_rdata    (mem_rdata),
    .epc_load     (epc_load),
    .epc_data     (epc_data),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .busy         (busy),
    .exc_cause    (exc_cause)
  );

  // Reference model: each accepted request expands into its list of per-cycle expectations.
  typedef struct packed {
    logic        el;
    logic        mr;
    logic        pl;
    logic [1:0]  sel;   // pc_next source: 0 zero, 1 vector byte, 2 epc_in
    logic [31:0] addr;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        m_cur;
  logic        m_busy;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {exc_opcode, exc_overflow, exc_div0, rte_req} = r;
  endtask

  task automatic drain();
    set_req(4'b0000);
    repeat (MW + 4) tick();
  endtask

  task automatic model_edge();
    int   c;
    rec_t r;
    if (!m_busy) begin
      if (exc_opcode || exc_overflow || exc_div0) begin
        c       = exc_opcode ? 1 : (exc_overflow ? 2 : 3);
        m_cause = 2'(c);
        m_epc   = pc_current - 32'd4;
        exp_q.push_back('{el: 1'b1, mr: 1'b0, pl: 1'b0, sel: 2'd0, addr: 32'(252 + c)});
        repeat (MW) exp_q.push_back('{el: 1'b0, mr: 1'b1, pl: 1'b0, sel: 2'd0, addr: 32'(252 + c)});
        exp_q.push_back('{el: 1'b0, mr: 1'b0, pl: 1'b1, sel: 2'd1, addr: 32'(252 + c)});
      end else if (rte_req) begin
        exp_q.push_back('{el: 1'b0, mr: 1'b0, pl: 1'b1, sel: 2'd2, addr: 32'd0});
      end
    end
    tick();
    if (exp_q.size() > 0) begin
      r      = exp_q.pop_front();
      m_busy = 1'b1;
    end else begin
      r      = '0;
      m_busy = 1'b0;
    end
    m_cur = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(4'b0000);
    pc_current = 32'd0; epc_in = 32'd0; mem_rdata = 32'd0;
    #3;
    n_checks++;
    if (obs !== 102'd0) begin n_fail++; $display("FAIL reset_async got=%h exp=0", obs); end
    set_req(4'b0100);
    repeat (2) tick();
    n_checks++;
    if (obs !== 102'd0) begin n_fail++; $display("FAIL reset_hold got=%h exp=0", obs); end
    reset = 1'b1;
    pc_current = 32'h20;
    tick();
    exp_v = {4'b1001, 32'h1C, 32'd254, 32'd0, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL first_edge got=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_overflow();
    pc_current = 32'h10; mem_rdata = 32'h80;
    set_req(4'b0100);
    tick();
    set_req(4'b0000);
    exp_v = {4'b1001, 32'hC, 32'd254, 32'd0, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ovf_save got=%h exp=%h", obs, exp_v); end
    for (int i = 0; i < MW; i++) begin
      tick();
      exp_v = {4'b0101, 32'hC, 32'd254, 32'd0, 2'b10};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL ovf_read%0d got=%h exp=%h", i, obs, exp_v); end
    end
    tick();
    exp_v = {4'b0011, 32'hC, 32'd254, 32'h80, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ovf_load got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {4'b0000, 32'hC, 32'd0, 32'd0, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ovf_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_priority();
    pc_current = 32'h40;
    set_req(4'b1111);
    tick();
    set_req(4'b0000);
    exp_v = {4'b1001, 32'h3C, 32'd253, 32'd0, 2'b01};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL priority got=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_rte();
    epc_in = 32'h44;
    set_req(4'b0001);
    tick();
    set_req(4'b0000);
    exp_v = {4'b0011, 32'h3C, 32'd0, 32'h44, 2'b01};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rte_load got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {4'b0000, 32'h3C, 32'd0, 32'd0, 2'b01};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rte_idle got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_div0_wrap();
    pc_current = 32'd0;
    set_req(4'b0010);
    tick();
    set_req(4'b0000);
    exp_v = {4'b1001, 32'hFFFF_FFFC, 32'd255, 32'd0, 2'b11};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL div0_wrap got=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_held_while_busy();
    pc_current = 32'h200; mem_rdata = 32'h1AB;
    set_req(4'b0100);
    tick();
    set_req(4'b0000);
    tick();
    set_req(4'b0010);
    pc_current = 32'h300;
    exp_v = {4'b0101, 32'h1FC, 32'd254, 32'd0, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL held_read1 got=%h exp=%h", obs, exp_v); end
    tick();
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL held_read2 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {4'b0011, 32'h1FC, 32'd254, 32'hAB, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL held_load got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {4'b0000, 32'h1FC, 32'd0, 32'd0, 2'b10};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL held_idle got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {4'b1001, 32'h2FC, 32'd255, 32'd0, 2'b11};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL held_accept got=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_reset_mid();
    pc_current = 32'h80; mem_rdata = 32'h80;
    set_req(4'b0100);
    tick();
    set_req(4'b0000);
    tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 102'd0) begin n_fail++; $display("FAIL mid_reset got=%h exp=0", obs); end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({pc_load, busy} !== 2'b00) begin n_fail++; $display("FAIL no_pc_load%0d got=%b exp=00", i, {pc_load, busy}); end
    end
    pc_current = 32'h100;
    set_req(4'b0010);
    tick();
    set_req(4'b0000);
    exp_v = {4'b1001, 32'hFC, 32'd255, 32'd0, 2'b11};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_rst_save got=%h exp=%h", obs, exp_v); end
    repeat (MW) tick();
    tick();
    exp_v = {4'b0011, 32'hFC, 32'd255, 32'h80, 2'b11};
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL post_rst_load got=%h exp=%h", obs, exp_v); end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] pc_exp;
    reset = 1'b0;
    set_req(4'b0000);
    tick();
    reset = 1'b1;
    exp_q.delete();
    m_busy = 1'b0; m_epc = 32'd0; m_cause = 2'b00; m_cur = '0;
    for (int n = 0; n < 500; n++) begin
      exc_opcode   = ($urandom_range(0, 7) == 0);
      exc_overflow = ($urandom_range(0, 5) == 0);
      exc_div0     = ($urandom_range(0, 5) == 0);
      rte_req      = ($urandom_range(0, 4) == 0);
      pc_current   = $urandom();
      epc_in       = $urandom();
      mem_rdata    = $urandom();
      model_edge();
      pc_exp = (m_cur.sel == 2'd1) ? {24'h0, mem_rdata[7:0]} :
               (m_cur.sel == 2'd2) ? epc_in : 32'd0;
      exp_v  = {m_cur.el, m_cur.mr, m_cur.pl, m_busy, m_epc, m_cur.addr, pc_exp, m_cause};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random_c%0d got=%h exp=%h", n, obs, exp_v); end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    m_busy = 1'b0; m_epc = 32'd0; m_cause = 2'b00; m_cur = '0;
    test_reset();
    test_overflow();
    test_priority();
    test_rte();
    test_div0_wrap();
    test_held_while_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
